// File: rtl/cbus_mem_responder.sv
// rtl/cbus_mem_responder.sv - cbus responder backed by an on-chip 64-bit word array
// Fixed first-beat latency, incrementing bursts that wrap inside the array, byte-strobed writes.
module cbus_mem_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_write,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  input  logic [7:0]  req_len,
  output logic        resp_ready,
  output logic        resp_last,
  output logic [63:0] resp_data,
  output logic        busy,
  output logic        bad_addr
);
  localparam int          AW       = $clog2(MEM_WORDS);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(MEM_WORDS) * 64'd8;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

  logic [63:0] mem [MEM_WORDS];

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    beat_q, beat_d;
  logic [7:0]    len_q, len_d;
  logic [AW-1:0] base_idx_q, base_idx_d;
  logic          is_write_q, is_write_d;
  logic          oor_q, oor_d;
  logic          resp_ready_q, resp_ready_d;
  logic          resp_last_q, resp_last_d;
  logic [63:0]   resp_data_q, resp_data_d;
  logic          busy_q, busy_d;
  logic          bad_addr_q, bad_addr_d;

  logic [63:0]   addr_off;
  logic [AW-1:0] acc_idx, cur_word, pres_word;
  logic          acc_oor, mem_we, pres, pres_last;
  logic          unused_bits;

  assign addr_off    = req_addr - BASE_ADDR;
  assign acc_idx     = addr_off[AW+2:3];
  assign acc_oor     = (req_addr < BASE_ADDR) || (req_addr >= END_ADDR);
  assign cur_word    = base_idx_q + AW'(beat_q);
  assign unused_bits = ^{req_size, addr_off[2:0], addr_off[63:AW+3]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    len_d        = len_q;
    base_idx_d   = base_idx_q;
    is_write_d   = is_write_q;
    oor_d        = oor_q;
    resp_ready_d = 1'b0;
    resp_last_d  = 1'b0;
    resp_data_d  = 64'd0;
    bad_addr_d   = 1'b0;
    mem_we       = 1'b0;
    pres         = 1'b0;
    pres_last    = 1'b0;
    pres_word    = base_idx_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          len_d      = req_len;
          is_write_d = req_is_write;
          base_idx_d = acc_idx;
          oor_d      = acc_oor;
          bad_addr_d = acc_oor;
          beat_d     = 8'd0;
          cnt_d      = 8'(LATENCY);
          if (LATENCY == 0) begin
            state_d   = BEAT;
            pres      = 1'b1;
            pres_word = acc_idx;
            pres_last = (req_len == 8'd0);
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req_valid) begin
          state_d = IDLE;
        end else if (cnt_q <= 8'd1) begin
          state_d   = BEAT;
          pres      = 1'b1;
          pres_word = base_idx_q;
          pres_last = (len_q == 8'd0);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BEAT: begin
        if (!req_valid) begin
          state_d = IDLE;
        end else begin
          // The beat shown this cycle commits at this edge with the live write data.
          mem_we = is_write_q && !oor_q;
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d    = beat_q + 8'd1;
            pres      = 1'b1;
            pres_word = cur_word + AW'(1);
            pres_last = ((beat_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pres) begin
      resp_ready_d = 1'b1;
      resp_last_d  = pres_last;
      resp_data_d  = (!is_write_d && !oor_d) ? mem[pres_word] : 64'd0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      beat_q       <= 8'd0;
      len_q        <= 8'd0;
      base_idx_q   <= '0;
      is_write_q   <= 1'b0;
      oor_q        <= 1'b0;
      resp_ready_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= 64'd0;
      busy_q       <= 1'b0;
      bad_addr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      base_idx_q   <= base_idx_d;
      is_write_q   <= is_write_d;
      oor_q        <= oor_d;
      resp_ready_q <= resp_ready_d;
      resp_last_q  <= resp_last_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
      bad_addr_q   <= bad_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (req_strobe[k]) mem[cur_word][8*k +: 8] <= req_data[8*k +: 8];
      end
    end
  end

  assign resp_ready = resp_ready_q;
  assign resp_last  = resp_last_q;
  assign resp_data  = resp_data_q;
  assign busy       = busy_q;
  assign bad_addr   = bad_addr_q;
endmodule
